// File: rtl/alu_mul_seq_pkg.sv
// Shared definitions for the shift-and-add multiplier sequencer: external ALU
// opcodes and the controller state encoding.
package alu_mul_seq_pkg;

  localparam int          MUL_WIDTH = 16;
  localparam logic [3:0]  ALU_ADD   = 4'b0100;
  localparam logic [3:0]  ALU_SLL   = 4'b0001;
  localparam logic [3:0]  ITER_LAST = 4'd15;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ADD   = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/alu_mul_seq_iter_cnt4.sv
// 4-bit iteration counter for the multiplier: synchronous clear, increment,
// and a terminal-count flag at the last iteration.
module iter_cnt4
  import alu_mul_seq_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear,
  input  logic       inc,
  output logic [3:0] count,
  output logic       tc
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc) begin
      count <= count + 4'd1;   // wraps 15 -> 0 on the final iteration
    end
  end

  assign tc = (count == ITER_LAST);

endmodule

// File: rtl/alu_mul_seq.sv
// Sequential shift-and-add multiplier that borrows an external ALU for both the
// partial-product add and the multiplicand shift; holds only control and registers.
module alu_mul_seq
  import alu_mul_seq_pkg::*;
#(
  parameter int WIDTH = MUL_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] opA,
  input  logic [WIDTH-1:0] opB,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product,
  output logic [WIDTH-1:0] alu_InA,
  output logic [WIDTH-1:0] alu_InB,
  output logic [3:0]       alu_Oper,
  output logic             alu_Cin,
  output logic             alu_invA,
  output logic             alu_invB,
  output logic             alu_sign,
  input  logic [WIDTH-1:0] alu_Out
);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] acc, mcand, mplier;
  logic             cnt_clear, cnt_inc, cnt_tc;
  logic [3:0]       count;

  iter_cnt4 u_iter_cnt4 (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (cnt_clear),
    .inc   (cnt_inc),
    .count (count),
    .tc    (cnt_tc)
  );

  assign alu_Cin  = 1'b0;
  assign alu_invA = 1'b0;
  assign alu_invB = 1'b0;
  assign alu_sign = 1'b0;

  // NOTE: every output of this block gets a default before the case so no
  // path leaves a signal unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    alu_Oper  = ALU_ADD;
    alu_InA   = '0;
    alu_InB   = '0;
    cnt_clear = 1'b0;
    cnt_inc   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          cnt_clear = 1'b1;
          state_nxt = ADD;
        end
      end
      ADD: begin
        busy      = 1'b1;
        alu_InA   = acc;
        alu_InB   = mplier[0] ? mcand : '0;
        state_nxt = abort ? IDLE : SHIFT;
      end
      SHIFT: begin
        busy     = 1'b1;
        alu_Oper = ALU_SLL;
        alu_InA  = mcand;
        alu_InB  = WIDTH'(1);
        if (abort) begin
          state_nxt = IDLE;
        end else begin
          cnt_inc   = 1'b1;
          state_nxt = cnt_tc ? DONE : ADD;
        end
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all of them sample
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      product <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            acc    <= '0;
            mcand  <= opA;
            mplier <= opB;
          end
        end
        ADD: begin
          if (!abort) acc <= alu_Out;
        end
        SHIFT: begin
          if (!abort) begin
            mcand  <= alu_Out;
            mplier <= mplier >> 1;
            // acc is final after the last add, so publish it as DONE begins
            if (cnt_tc) product <= acc;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mul_seq.sv
// Self-checking bench for alu_mul_seq with a behavioural ALU and a plain
// arithmetic multiply reference; randomized plus directed scenarios.
module tb_alu_mul_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [15:0] opA = '0;
  logic [15:0] opB = '0;
  logic        busy, done;
  logic [15:0] product, alu_InA, alu_InB, alu_Out;
  logic [3:0]  alu_Oper;
  logic        alu_Cin, alu_invA, alu_invB, alu_sign;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  alu_mul_seq #(.WIDTH(16)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .abort    (abort),
    .opA      (opA),
    .opB      (opB),
    .busy     (busy),
    .done     (done),
    .product  (product),
    .alu_InA  (alu_InA),
    .alu_InB  (alu_InB),
    .alu_Oper (alu_Oper),
    .alu_Cin  (alu_Cin),
    .alu_invA (alu_invA),
    .alu_invB (alu_invB),
    .alu_sign (alu_sign),
    .alu_Out  (alu_Out)
  );

  // Stand-in for the external ALU: add and shift-left are all this block uses.
  always_comb begin
    case (alu_Oper)
      4'b0100: alu_Out = alu_InA + alu_InB;
      4'b0001: alu_Out = alu_InA << alu_InB[3:0];
      default: alu_Out = 16'h0000;
    endcase
  end

  function automatic logic [15:0] ref_mul(input logic [15:0] a, input logic [15:0] b);
    logic [31:0] full;
    full = 32'(a) * 32'(b);
    return full[15:0];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else n_pass++;
  endtask

  // Called right after the accepting edge; returns cycles until done is seen.
  task automatic wait_done(input int budget, output int lat, output int busy_cyc);
    lat = 1;
    busy_cyc = 0;
    while (done !== 1'b1 && lat <= budget) begin
      if (busy === 1'b1) busy_cyc++;
      step();
      lat++;
    end
  endtask

  task automatic do_mul(input logic [15:0] a, input logic [15:0] b, input string name);
    int lat, bc;
    opA = a; opB = b; start = 1'b1;
    step();
    start = 1'b0;
    wait_done(60, lat, bc);
    chk({name, "_latency"}, lat, 33);
    chk({name, "_busy_cycles"}, bc, 32);
    step();
    chk({name, "_done_one_cycle"}, done, 0);
    chk({name, "_product"}, product, ref_mul(a, b));
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_product", product, 0);
    chk("reset_alu_oper", alu_Oper, 4'b0100);
    chk("reset_alu_ina", alu_InA, 0);
    chk("reset_alu_inb", alu_InB, 0);
    chk("reset_tied_low", {alu_Cin, alu_invA, alu_invB, alu_sign}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_basic();
    do_mul(16'd3, 16'd5, "basic_3x5");
  endtask

  task automatic test_wrap();
    do_mul(16'hFFFF, 16'hFFFF, "wrap_ffff");
    do_mul(16'h0100, 16'h0100, "wrap_0100");
    do_mul(16'h0000, 16'h1234, "zero_operand");
  endtask

  task automatic test_random();
    logic [15:0] a, b;
    for (int i = 0; i < 8; i++) begin
      a = 16'($urandom);
      b = 16'($urandom);
      do_mul(a, b, $sformatf("rand%0d", i));
    end
  endtask

  task automatic test_ignore_start();
    int lat, bc;
    opA = 16'd7; opB = 16'd9; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 4; i++) step();
    opA = 16'd2; opB = 16'd2; start = 1'b1;
    for (int i = 0; i < 5; i++) step();
    start = 1'b0;
    wait_done(60, lat, bc);
    lat = lat + 9;
    chk("ignore_start_latency", lat, 33);
    step();
    chk("ignore_start_product", product, 63);
  endtask

  task automatic test_abort();
    logic [15:0] prev;
    int seen;
    prev = product;
    opA = 16'd4; opB = 16'd4; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 9; i++) step();
    chk("abort_busy_before", busy, 1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_busy_low", busy, 0);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (done === 1'b1) seen++;
      step();
    end
    chk("abort_no_done", seen, 0);
    chk("abort_product_kept", product, prev);
  endtask

  task automatic test_start_beats_abort();
    int lat, bc;
    opA = 16'd11; opB = 16'd13; start = 1'b1; abort = 1'b1;
    step();
    start = 1'b0; abort = 1'b0;
    chk("start_abort_accepted", busy, 1);
    wait_done(60, lat, bc);
    chk("start_abort_latency", lat, 33);
    step();
    chk("start_abort_product", product, 143);
  endtask

  task automatic test_reset_mid();
    int seen;
    opA = 16'd6; opB = 16'd6; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 19; i++) step();
    #2;
    rst_n = 1'b0;
    #1;
    chk("midreset_busy", busy, 0);
    chk("midreset_done", done, 0);
    chk("midreset_product", product, 0);
    chk("midreset_alu", {alu_InA, alu_InB}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (done === 1'b1 || busy === 1'b1) seen++;
    end
    chk("midreset_no_activity", seen, 0);
  endtask

  task automatic test_first_start_after_reset();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    opA = 16'd10; opB = 16'd10; start = 1'b1;
    step();
    start = 1'b0;
    chk("first_edge_accept", busy, 1);
    for (int i = 0; i < 40; i++) step();
    chk("first_edge_product", product, 100);
  endtask

  task automatic test_back_to_back();
    int t = 0, t1 = -1, t2 = -1;
    logic [15:0] p1 = '0;
    opA = 16'd2; opB = 16'd3; start = 1'b1;
    step();
    opA = 16'd4; opB = 16'd5;
    while (t2 < 0 && t < 120) begin
      t++;
      if (done === 1'b1) begin
        if (t1 < 0) t1 = t;
        else t2 = t;
      end
      step();
      if (t1 == t - 1 && t2 < 0) p1 = product;
    end
    start = 1'b0;
    chk("b2b_spacing", t2 - t1, 34);
    chk("b2b_product1", p1, 6);
    chk("b2b_product2", product, 20);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_random();
    test_ignore_start();
    test_abort();
    test_start_beats_abort();
    test_reset_mid();
    test_first_start_after_reset();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
